reg_console: RTL and testbench
==============================

# reg_console

Console output controller on the CPU's peripheral register port. Decodes `register_index`/`register_read`/`register_write`, buffers characters written to register 0 in a small FIFO, and serializes them onto a UART line (8N1, LSB first). It also exposes a status register and a programmable bit divisor. It replaces direct character capture on register 0 with a real transmit path, and sits between the ulisp core and the board pin.

## Interface

- `CLK_DIVIDE`, 16, reset value of the divisor register (clock cycles per UART bit).
- `FIFO_DEPTH`, 8, TX FIFO entries; must be a power of two, 2..16.
- `clk`  in  1  core clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `register_index`  in  7  register address from the CPU.
- `register_read`  in  1  read strobe, single cycle.
- `register_write`  in  1  write strobe, single cycle.
- `register_write_value`  in  16  write data.
- `register_read_value`  out  16  registered read data.
- `uart_tx`  out  1  serial output, idles high.
- `tx_busy`  out  1  high while a frame is being shifted.

## Operation

- Register 0 (TXDATA):
  - Write pushes `register_write_value[7:0]`; bits 15:8 are ignored.
  - A write while the FIFO is full (and no pop occurs that cycle) drops the byte and sets sticky `overflow`.
  - A read returns 0.
- Register 1 (STATUS), read:
  - bit0 = full; bit1 = empty; bit2 = `tx_busy`; bit3 = `overflow`.
  - bits[8:4] = FIFO count (0..FIFO_DEPTH); all other bits 0.
- Register 1 (STATUS), write: bit3 = 1 clears `overflow`; all other bits ignored.
- Register 2 (DIVISOR): 16-bit read/write. A value of 0 behaves as 1. A new value takes effect at the next bit boundary, never mid-bit.
- Indices 3..127: reads return 0; writes have no effect.
- Read and write in the same cycle are both performed. The read returns the pre-write value.
- Push and pop in the same cycle with the FIFO full: the push is accepted and the count is unchanged.
- Overflow set and clear in the same cycle: set wins.
- TX state machine states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. The head is popped into the shift register on that transition.
  - START drives 0 for one bit time, then → DATA.
  - DATA drives shift[0] for each of 8 bits (3-bit bit counter), then → STOP.
  - STOP drives 1 for one bit time. On completion it goes → START with a pop if the FIFO is non-empty, else → IDLE. There is no idle gap between queued frames.
- Bit timer: counts divisor−1 down to 0; 16-bit width; reloads at each bit boundary.
- `tx_busy` = (state ≠ IDLE).
- Reset (asserted at any time, including mid-frame) takes effect immediately:
  - `uart_tx` = 1, `tx_busy` = 0, `register_read_value` = 0.
  - FIFO empty, `overflow` = 0, divisor = CLK_DIVIDE, state = IDLE.
  - Any partial frame is abandoned.

## Timing

- Register writes take effect at the rising edge on which the strobe is sampled high.
- Read latency is 1 cycle. `register_read_value` is updated at the edge that samples `register_read` high, and holds until the next read.
- Write to TXDATA at edge N with the FIFO empty and the state machine IDLE:
  - count becomes 1 after edge N;
  - the pop and START transition happen at edge N+1, so `uart_tx` falls after edge N+1;
  - count returns to 0 after edge N+1.
- Frame length is exactly 10 × divisor cycles, from the `uart_tx` falling edge to the end of the stop bit.
- Back-to-back queued bytes produce frames spaced exactly 10 × divisor cycles apart.
- STATUS reflects the state registered before the sampling edge, so a write and a STATUS read in the same cycle show the old count.

## Test plan

- Reset values: assert `reset_n`=0 for 3 cycles, release, then read STATUS and DIVISOR. Required:
  - `uart_tx`=1, `tx_busy`=0;
  - STATUS=0x0002;
  - DIVISOR=16.
- Single byte with divisor 4: write 0x0041 to register 0. Required:
  - `uart_tx` low starting 1 cycle after the write edge, for 4 cycles;
  - then data bits 1,0,0,0,0,0,1,0, 4 cycles each;
  - then high; `tx_busy` high for exactly 40 cycles.
- Overflow with divisor 1000: write 10 bytes on consecutive cycles. Required:
  - STATUS shows count=8, full=1, overflow=1 (first byte already popped, 9th kept, 10th dropped);
  - writing 0x0008 to STATUS clears bit3 only.
- Back-to-back: queue 0x55 and 0xAA with divisor 2. Required: two frames totalling 40 cycles, `tx_busy` continuously high, no idle gap.
- Divisor change mid-frame: divisor 8, send a byte, write divisor 2 during data bit 3. Required: bit 3 still lasts 8 cycles; bit 4 onward lasts 2 cycles.
- Reset mid-frame: assert `reset_n`=0 during data bit 5. Required:
  - `uart_tx`=1 immediately, without waiting for `clk`;
  - FIFO empty after release;
  - no further frame bits transmitted.

Source files
------------

// File: rtl/reg_console.sv
// Console output controller: CPU register port, TX byte FIFO and an 8N1 UART
// transmitter with a programmable bit divisor.
module reg_console #(
  parameter int unsigned CLK_DIVIDE = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [6:0] IDX_TXDATA  = 7'd0;
  localparam logic [6:0] IDX_STATUS  = 7'd1;
  localparam logic [6:0] IDX_DIVISOR = 7'd2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   divisor_q, divisor_d;
  logic [15:0]   rdata_q, rdata_d;
  tx_state_e     state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic        full, empty, push_req, push, pop, bit_end;
  logic [15:0] reload, status;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign bit_end  = (timer_q == '0);
  assign push_req = register_write && (register_index == IDX_TXDATA);
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign pop      = !empty && ((state_q == S_IDLE) || (state_q == S_STOP && bit_end));
  assign push     = push_req && (!full || pop);
  assign reload   = (divisor_q == '0) ? 16'd0 : divisor_q - 16'd1;
  assign status   = {7'd0, 5'(count_q), overflow_q, tx_busy, empty, full};

  assign tx_busy             = (state_q != S_IDLE);
  assign uart_tx             = tx_q;
  assign register_read_value = rdata_q;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    divisor_d  = divisor_q;
    rdata_d    = rdata_q;
    state_d    = state_q;
    timer_d    = timer_q - 16'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set is evaluated last so it wins over a same-cycle clear.
    if (register_write && register_index == IDX_STATUS && register_write_value[3])
      overflow_d = 1'b0;
    if (push_req && full && !pop)
      overflow_d = 1'b1;

    if (register_write && register_index == IDX_DIVISOR)
      divisor_d = register_write_value;

    if (register_read) begin
      case (register_index)
        IDX_STATUS:  rdata_d = status;
        IDX_DIVISOR: rdata_d = divisor_q;
        default:     rdata_d = '0;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        timer_d = timer_q;
        if (pop) begin
          state_d = S_START;
          shift_d = fifo_mem[rd_ptr_q];
          timer_d = reload;
        end
      end
      S_START: if (bit_end) begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
        timer_d   = reload;
      end
      S_DATA: if (bit_end) begin
        shift_d   = shift_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        timer_d   = reload;
        if (bit_cnt_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: if (bit_end) begin
        timer_d = reload;
        if (pop) begin
          state_d = S_START;
          shift_d = fifo_mem[rd_ptr_q];
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line is registered from next-state so the pin never glitches.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      divisor_q  <= 16'(CLK_DIVIDE);
      rdata_q    <= '0;
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      divisor_q  <= divisor_d;
      rdata_q    <= rdata_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // NOTE: storage is left unreset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= register_write_value[7:0];
  end

endmodule

// File: tb/tb_reg_console.sv
// Directed bench for reg_console: register map, frame timing, FIFO overflow,
// divisor changes and asynchronous reset.
module tb_reg_console;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  register_index = '0;
  logic        register_read = 1'b0;
  logic        register_write = 1'b0;
  logic [15:0] register_write_value = '0;
  logic [15:0] register_read_value;
  logic        uart_tx;
  logic        tx_busy;

  int vectors = 0;
  int miscompares = 0;

  reg_console #(.CLK_DIVIDE(16), .FIFO_DEPTH(8)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .uart_tx              (uart_tx),
    .tx_busy              (tx_busy)
  );

  always #5 clk = ~clk;

  // Tasks are entered just after a falling edge and return just after the next one.
  task automatic reg_write(input logic [6:0] idx, input logic [15:0] val);
    register_index = idx; register_write_value = val; register_write = 1'b1;
    @(negedge clk);
    register_write = 1'b0;
  endtask

  task automatic reg_read(input logic [6:0] idx, output logic [15:0] val);
    register_index = idx; register_read = 1'b1;
    @(negedge clk);
    register_read = 1'b0;
    val = register_read_value;
  endtask

  task automatic capture(input int n, output logic [127:0] wave, output int busy);
    wave = '1; busy = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      wave[k] = uart_tx;
      busy += int'(tx_busy);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    else if (p <= 8) return b[p-1];
    else return 1'b1;
  endfunction

  function automatic logic [127:0] exp_frame(input logic [7:0] b, input int div);
    logic [127:0] w = '1;
    for (int k = 0; k < 10 * div; k++) w[k] = exp_bit(b, k / div);
    return w;
  endfunction

  task automatic test_reset();
    logic [15:0] rv;
    repeat (3) @(negedge clk);
    vectors++;
    if ({uart_tx, tx_busy, register_read_value} !== {1'b1, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_outputs: got tx=%b busy=%b rd=%h, want tx=1 busy=0 rd=0000",
               uart_tx, tx_busy, register_read_value);
    end
    reset_n = 1'b1;
    reg_read(7'd1, rv);
    vectors++;
    if (rv !== 16'h0002) begin
      miscompares++; $display("FAIL reset_status: got %h want 0002", rv);
    end
    reg_read(7'd2, rv);
    vectors++;
    if (rv !== 16'd16) begin
      miscompares++; $display("FAIL reset_divisor: got %0d want 16", rv);
    end
  endtask

  task automatic test_registers();
    logic [15:0] rv;
    reg_write(7'd2, 16'h1234);
    reg_read(7'd2, rv);
    vectors++;
    if (rv !== 16'h1234) begin
      miscompares++; $display("FAIL divisor_rw: got %h want 1234", rv);
    end
    reg_write(7'd77, 16'hFFFF);
    reg_read(7'd77, rv);
    vectors++;
    if (rv !== 16'h0000) begin
      miscompares++; $display("FAIL unmapped_read: got %h want 0000", rv);
    end
    // Simultaneous read and write of the divisor returns the old value.
    register_index = 7'd2; register_write_value = 16'h0004;
    register_read = 1'b1; register_write = 1'b1;
    @(negedge clk);
    register_read = 1'b0; register_write = 1'b0;
    vectors++;
    if (register_read_value !== 16'h1234) begin
      miscompares++; $display("FAIL read_before_write: got %h want 1234", register_read_value);
    end
    reg_read(7'd2, rv);
    vectors++;
    if (rv !== 16'h0004) begin
      miscompares++; $display("FAIL write_after_read: got %h want 0004", rv);
    end
  endtask

  task automatic test_single_byte();
    logic [127:0] wave, expw;
    int busy;
    logic [15:0] rv;
    reg_write(7'd2, 16'd4);
    reg_write(7'd0, 16'h0041);
    vectors++;
    if (uart_tx !== 1'b1) begin
      miscompares++; $display("FAIL single_latency: got tx=%b want 1 one cycle after write", uart_tx);
    end
    @(negedge clk);
    capture(40, wave, busy);
    expw = exp_frame(8'h41, 4);
    vectors++;
    if (wave !== expw) begin
      miscompares++; $display("FAIL single_wave: got %h want %h", wave[39:0], expw[39:0]);
    end
    vectors++;
    if (busy !== 40) begin
      miscompares++; $display("FAIL single_busy: got %0d cycles want 40", busy);
    end
    @(negedge clk);
    reg_read(7'd1, rv);
    vectors++;
    if (rv !== 16'h0002 || uart_tx !== 1'b1) begin
      miscompares++; $display("FAIL single_idle: got status=%h tx=%b want 0002 tx=1", rv, uart_tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] wave, expw;
    int busy;
    reg_write(7'd2, 16'd2);
    reg_write(7'd0, 16'h3355);
    reg_write(7'd0, 16'h00AA);
    capture(40, wave, busy);
    expw = '1;
    for (int k = 0; k < 40; k++)
      expw[k] = (k < 20) ? exp_bit(8'h55, k / 2) : exp_bit(8'hAA, (k - 20) / 2);
    vectors++;
    if (wave !== expw) begin
      miscompares++; $display("FAIL b2b_wave: got %h want %h", wave[39:0], expw[39:0]);
    end
    vectors++;
    if (busy !== 40) begin
      miscompares++; $display("FAIL b2b_busy: got %0d cycles want 40", busy);
    end
    @(negedge clk);
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL b2b_end: got busy=%b want 0", tx_busy);
    end
  endtask

  task automatic test_div_zero();
    logic [127:0] wave, expw;
    int busy;
    reg_write(7'd2, 16'd0);
    reg_write(7'd0, 16'h000F);
    @(negedge clk);
    capture(10, wave, busy);
    expw = exp_frame(8'h0F, 1);
    vectors++;
    if (wave !== expw || busy !== 10) begin
      miscompares++;
      $display("FAIL div_zero: got wave=%h busy=%0d want wave=%h busy=10", wave[9:0], busy, expw[9:0]);
    end
  endtask

  task automatic test_div_change();
    logic [127:0] wave, expw;
    int busy = 0;
    reg_write(7'd2, 16'd8);
    reg_write(7'd0, 16'h0035);
    @(negedge clk);
    wave = '1;
    for (int k = 0; k < 50; k++) begin
      if (k > 0) @(negedge clk);
      wave[k] = uart_tx;
      busy += int'(tx_busy);
      // k = 34 lies inside data bit 3 (cycles 32..39 of the frame).
      if (k == 34) begin
        register_index = 7'd2; register_write_value = 16'd2; register_write = 1'b1;
      end else begin
        register_write = 1'b0;
      end
    end
    expw = '1;
    for (int k = 0; k < 50; k++)
      expw[k] = (k < 40) ? exp_bit(8'h35, k / 8) : exp_bit(8'h35, 5 + (k - 40) / 2);
    vectors++;
    if (wave !== expw) begin
      miscompares++; $display("FAIL divchg_wave: got %h want %h", wave[49:0], expw[49:0]);
    end
    vectors++;
    if (busy !== 50) begin
      miscompares++; $display("FAIL divchg_busy: got %0d cycles want 50", busy);
    end
    @(negedge clk);
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL divchg_end: got busy=%b want 0", tx_busy);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] rv;
    reg_write(7'd2, 16'd1000);
    for (int i = 0; i < 10; i++) reg_write(7'd0, 16'(8'h30 + i));
    reg_read(7'd1, rv);
    vectors++;
    if (rv !== 16'h008D) begin
      miscompares++; $display("FAIL overflow_status: got %h want 008D", rv);
    end
    reg_write(7'd1, 16'hFFF7);
    reg_read(7'd1, rv);
    vectors++;
    if (rv !== 16'h008D) begin
      miscompares++; $display("FAIL overflow_keep: got %h want 008D", rv);
    end
    reg_write(7'd1, 16'h0008);
    reg_read(7'd1, rv);
    vectors++;
    if (rv !== 16'h0085) begin
      miscompares++; $display("FAIL overflow_clear: got %h want 0085", rv);
    end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_midframe();
    logic [15:0] rv;
    int lows = 0, busy = 0;
    reg_write(7'd2, 16'd4);
    reg_write(7'd0, 16'h0000);
    reg_write(7'd0, 16'h00FF);
    repeat (25) @(negedge clk);
    vectors++;
    if (uart_tx !== 1'b0 || tx_busy !== 1'b1) begin
      miscompares++; $display("FAIL midframe_bit5: got tx=%b busy=%b want tx=0 busy=1", uart_tx, tx_busy);
    end
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if (uart_tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL midframe_async: got tx=%b busy=%b want tx=1 busy=0", uart_tx, tx_busy);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    reg_read(7'd1, rv);
    vectors++;
    if (rv !== 16'h0002) begin
      miscompares++; $display("FAIL midframe_status: got %h want 0002", rv);
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      lows += int'(!uart_tx);
      busy += int'(tx_busy);
    end
    vectors++;
    if (lows !== 0 || busy !== 0) begin
      miscompares++; $display("FAIL midframe_quiet: got low=%0d busy=%0d want 0 0", lows, busy);
    end
  endtask

  initial begin
    test_reset();
    test_registers();
    test_single_byte();
    test_back_to_back();
    test_div_zero();
    test_div_change();
    test_overflow();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
